// File: rtl/fpu_operand_unpack_pkg.sv
// Shared FPU constants and the unpacked-operand record used by the operand unpack slice.
package fpu_operand_unpack_pkg;

    localparam logic [31:0] CanonicalNan = 32'h7fc0_0000;
    localparam logic [7:0]  ExpAllOnes   = 8'hFF;

    // RISC-V FCLASS bit positions
    localparam int unsigned FclassNegInf  = 0;
    localparam int unsigned FclassNegNorm = 1;
    localparam int unsigned FclassNegSub  = 2;
    localparam int unsigned FclassNegZero = 3;
    localparam int unsigned FclassPosZero = 4;
    localparam int unsigned FclassPosSub  = 5;
    localparam int unsigned FclassPosNorm = 6;
    localparam int unsigned FclassPosInf  = 7;
    localparam int unsigned FclassSnan    = 8;
    localparam int unsigned FclassQnan    = 9;
    localparam int unsigned FclassWidth   = 10;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] sig;
        logic        is_inf;
        logic        is_nan;
        logic        is_snan;
        logic        is_zero;
        logic        is_sub;
    } op_t;

    typedef struct packed {
        op_t                    a;
        op_t                    b;
        logic [FclassWidth-1:0] fclass_a;
    } entry_t;

endpackage

// File: rtl/fpu_operand_unpack_if.sv
// Operand-in / unpacked-result-out handshake bundle.
interface fpu_operand_unpack_if;

    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        sign_a_o;
    logic        sign_b_o;
    logic [7:0]  exp_a_o;
    logic [7:0]  exp_b_o;
    logic [23:0] sig_a_o;
    logic [23:0] sig_b_o;
    logic        is_inf_a_o;
    logic        is_inf_b_o;
    logic        is_nan_a_o;
    logic        is_nan_b_o;
    logic        is_zero_a_o;
    logic        is_zero_b_o;
    logic        is_sub_a_o;
    logic        is_sub_b_o;
    logic        is_signaling_o;
    logic [9:0]  fclass_a_o;

    // Unpack block side
    modport slave (
        input  in_valid_i, op_a_i, op_b_i, out_ready_i,
        output in_ready_o, out_valid_o, sign_a_o, sign_b_o, exp_a_o, exp_b_o, sig_a_o, sig_b_o,
               is_inf_a_o, is_inf_b_o, is_nan_a_o, is_nan_b_o, is_zero_a_o, is_zero_b_o,
               is_sub_a_o, is_sub_b_o, is_signaling_o, fclass_a_o
    );

    // Producer / consumer side
    modport master (
        output in_valid_i, op_a_i, op_b_i, out_ready_i,
        input  in_ready_o, out_valid_o, sign_a_o, sign_b_o, exp_a_o, exp_b_o, sig_a_o, sig_b_o,
               is_inf_a_o, is_inf_b_o, is_nan_a_o, is_nan_b_o, is_zero_a_o, is_zero_b_o,
               is_sub_a_o, is_sub_b_o, is_signaling_o, fclass_a_o
    );

endinterface

// File: rtl/fpu_operand_unpack_classify.sv
// Combinational decode of one IEEE-754 single: fields, class flags and FCLASS mask.
module fpu_classify
    import fpu_operand_unpack_pkg::*;
(
    input  logic [31:0]            operand_i,
    output op_t                    op_o,
    output logic [FclassWidth-1:0] fclass_o
);

    logic [7:0]  exp;
    logic [22:0] man;
    logic        exp_zero;
    logic        exp_ones;
    logic        man_zero;

    assign exp      = operand_i[30:23];
    assign man      = operand_i[22:0];
    assign exp_zero = (exp == 8'h00);
    assign exp_ones = (exp == ExpAllOnes);
    assign man_zero = (man == 23'h0);

    // Field extraction and per-class flags; hidden bit only for nonzero exponents
    always_comb begin
        op_o         = '0;
        op_o.sign    = operand_i[31];
        op_o.exp     = exp;
        op_o.sig     = {~exp_zero, man};
        op_o.is_inf  = exp_ones & man_zero;
        op_o.is_nan  = exp_ones & ~man_zero;
        op_o.is_snan = exp_ones & ~man_zero & ~man[22];
        op_o.is_zero = exp_zero & man_zero;
        op_o.is_sub  = exp_zero & ~man_zero;
    end

    // One-hot FCLASS; NaN is tested first because its sign is irrelevant
    always_comb begin
        fclass_o = '0;
        if (op_o.is_nan) begin
            if (op_o.is_snan) fclass_o[FclassSnan] = 1'b1;
            else              fclass_o[FclassQnan] = 1'b1;
        end else if (op_o.is_inf) begin
            if (op_o.sign) fclass_o[FclassNegInf] = 1'b1;
            else           fclass_o[FclassPosInf] = 1'b1;
        end else if (op_o.is_zero) begin
            if (op_o.sign) fclass_o[FclassNegZero] = 1'b1;
            else           fclass_o[FclassPosZero] = 1'b1;
        end else if (op_o.is_sub) begin
            if (op_o.sign) fclass_o[FclassNegSub] = 1'b1;
            else           fclass_o[FclassPosSub] = 1'b1;
        end else begin
            if (op_o.sign) fclass_o[FclassNegNorm] = 1'b1;
            else           fclass_o[FclassPosNorm] = 1'b1;
        end
    end

endmodule

// File: rtl/fpu_operand_unpack.sv
// Operand unpack stage: decodes both operands and buffers results in a 2-entry skid buffer.
module fpu_operand_unpack
    import fpu_operand_unpack_pkg::*;
(
    input logic                 clk_i,
    input logic                 reset_i,
    fpu_operand_unpack_if.slave bus
);

    op_t                    op_a;
    op_t                    op_b;
    logic [FclassWidth-1:0] fclass_a;
    logic [FclassWidth-1:0] unused_fclass_b;
    entry_t                 in_entry;

    entry_t     e0_q, e0_d;
    entry_t     e1_q, e1_d;
    logic [1:0] cnt_q, cnt_d;
    logic       rdy_q, rdy_d;
    logic       accept;
    logic       drain;

    fpu_classify u_class_a (
        .operand_i (bus.op_a_i),
        .op_o      (op_a),
        .fclass_o  (fclass_a)
    );

    fpu_classify u_class_b (
        .operand_i (bus.op_b_i),
        .op_o      (op_b),
        .fclass_o  (unused_fclass_b)
    );

    assign in_entry = '{a: op_a, b: op_b, fclass_a: fclass_a};
    assign accept   = bus.in_valid_i & rdy_q;
    assign drain    = (cnt_q != 2'd0) & bus.out_ready_i;

    // Skid-buffer next state: e0 is always the head presented on the outputs
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        unique case ({accept, drain})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = in_entry;
                else               e1_d = in_entry;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            // Accept needs rdy_q (cnt < 2) and drain needs cnt > 0, so cnt is 1 here
            2'b11: begin
                e0_d = in_entry;
            end
            default: ;
        endcase
        // Ready is registered from next occupancy, so it never sees out_ready_i combinationally
        rdy_d = (cnt_d != 2'd2);
    end

    // State registers; reset wipes buffered results so nothing stale is emitted
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
            rdy_q <= 1'b0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
        end
    end

    assign bus.in_ready_o     = rdy_q;
    assign bus.out_valid_o    = (cnt_q != 2'd0);
    assign bus.sign_a_o       = e0_q.a.sign;
    assign bus.sign_b_o       = e0_q.b.sign;
    assign bus.exp_a_o        = e0_q.a.exp;
    assign bus.exp_b_o        = e0_q.b.exp;
    assign bus.sig_a_o        = e0_q.a.sig;
    assign bus.sig_b_o        = e0_q.b.sig;
    assign bus.is_inf_a_o     = e0_q.a.is_inf;
    assign bus.is_inf_b_o     = e0_q.b.is_inf;
    assign bus.is_nan_a_o     = e0_q.a.is_nan;
    assign bus.is_nan_b_o     = e0_q.b.is_nan;
    assign bus.is_zero_a_o    = e0_q.a.is_zero;
    assign bus.is_zero_b_o    = e0_q.b.is_zero;
    assign bus.is_sub_a_o     = e0_q.a.is_sub;
    assign bus.is_sub_b_o     = e0_q.b.is_sub;
    assign bus.is_signaling_o = e0_q.a.is_snan | e0_q.b.is_snan;
    assign bus.fclass_a_o     = e0_q.fclass_a;

endmodule

// File: tb/tb_fpu_operand_unpack.sv
// Randomized scoreboard bench for fpu_operand_unpack with directed corner cases.
module tb_fpu_operand_unpack;
    import fpu_operand_unpack_pkg::*;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [23:0] g;
        logic        inf;
        logic        nan;
        logic        zero;
        logic        sub;
        logic        snan;
        logic [9:0]  cls;
    } ref_t;

    logic clk;
    logic reset_i;
    logic rand_rdy;
    int   n_vec;
    int   n_err;
    logic [84:0] exp_q[$];

    fpu_operand_unpack_if bus ();

    fpu_operand_unpack dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: classification from field values with plain arithmetic
    function automatic ref_t ref_op(input logic [31:0] x);
        ref_t r;
        int unsigned e;
        int unsigned m;
        int unsigned k;
        e      = (x >> 23) % 256;
        m      = x % (1 << 23);
        r.s    = (x >= 32'h8000_0000);
        r.e    = e[7:0];
        k      = m + ((e != 0) ? (1 << 23) : 0);
        r.g    = k[23:0];
        r.inf  = (e == 255) && (m == 0);
        r.nan  = (e == 255) && (m != 0);
        r.snan = r.nan && (m < (1 << 22));
        r.zero = (e == 0) && (m == 0);
        r.sub  = (e == 0) && (m != 0);
        if (r.nan)       k = r.snan ? 8 : 9;
        else if (r.inf)  k = r.s ? 0 : 7;
        else if (r.zero) k = r.s ? 3 : 4;
        else if (r.sub)  k = r.s ? 2 : 5;
        else             k = r.s ? 1 : 6;
        r.cls = 10'(1 << k);
        return r;
    endfunction

    function automatic logic [84:0] model(input logic [31:0] a, input logic [31:0] b);
        ref_t ra;
        ref_t rb;
        ra = ref_op(a);
        rb = ref_op(b);
        return {ra.s, ra.e, ra.g, ra.inf, ra.nan, ra.zero, ra.sub,
                rb.s, rb.e, rb.g, rb.inf, rb.nan, rb.zero, rb.sub,
                ra.snan | rb.snan, ra.cls};
    endfunction

    function automatic logic [84:0] observed();
        return {bus.sign_a_o, bus.exp_a_o, bus.sig_a_o, bus.is_inf_a_o, bus.is_nan_a_o,
                bus.is_zero_a_o, bus.is_sub_a_o,
                bus.sign_b_o, bus.exp_b_o, bus.sig_b_o, bus.is_inf_b_o, bus.is_nan_b_o,
                bus.is_zero_b_o, bus.is_sub_b_o, bus.is_signaling_o, bus.fclass_a_o};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Monitor: pops on every output handshake, peeks while stalled, pushes on every accept
    always @(negedge clk) begin
        if (reset_i) begin
            if (bus.out_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 128'(observed()), 128'(0));
                end else if (bus.out_ready_i) begin
                    check("scoreboard", 128'(observed()), 128'(exp_q.pop_front()));
                end else begin
                    check("held_output", 128'(observed()), 128'(exp_q[0]));
                end
            end
            if (bus.in_valid_i && bus.in_ready_o) exp_q.push_back(model(bus.op_a_i, bus.op_b_i));
        end
    end

    // Random consumer back-pressure during the streaming phase
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.out_ready_i = 1'($urandom_range(0, 1));
        end
    end

    // Present a pair (called at posedge+1) and return #1 after the edge that accepts it
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        logic acc;
        int   w;
        acc = 1'b0;
        w   = 0;
        bus.in_valid_i = 1'b1;
        bus.op_a_i     = a;
        bus.op_b_i     = b;
        while (!acc && w < 200) begin
            @(negedge clk);
            acc = bus.in_ready_o;
            @(posedge clk);
            #1;
            w++;
        end
        if (!acc) check("accept_timeout", 128'(acc), 128'(1));
    endtask

    task automatic directed(input logic [31:0] a, input logic [31:0] b);
        bus.out_ready_i = 1'b1;
        send(a, b);
        bus.in_valid_i = 1'b0;
        check("dir_out_valid", 128'(bus.out_valid_o), 128'(1));
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 4))
            0: x[30:23] = 8'h00;
            1: x[30:23] = 8'hFF;
            default: ;
        endcase
        if ($urandom_range(0, 3) == 0) x[22:0] = 23'h0;
        return x;
    endfunction

    initial begin
        logic never_valid;
        n_vec           = 0;
        n_err           = 0;
        rand_rdy        = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.op_a_i      = '0;
        bus.op_b_i      = '0;
        bus.out_ready_i = 1'b0;
        reset_i         = 1'b1;
        #1 reset_i = 1'b0;
        #2;
        check("rst_out_valid", 128'(bus.out_valid_o), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready_o), 128'(0));
        check("rst_outputs", 128'(observed()), 128'(0));
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b1;
        #1 check("ready_before_edge", 128'(bus.in_ready_o), 128'(0));
        @(posedge clk);
        #1 check("ready_after_reset", 128'(bus.in_ready_o), 128'(1));

        // 1.0 and -2.0
        directed(32'h3F80_0000, 32'hC000_0000);
        check("one_sign_a", 128'(bus.sign_a_o), 128'(0));
        check("one_exp_a", 128'(bus.exp_a_o), 128'(8'h7F));
        check("one_sig_a", 128'(bus.sig_a_o), 128'(24'h80_0000));
        check("one_fclass_a", 128'(bus.fclass_a_o), 128'(10'h040));
        check("two_sign_b", 128'(bus.sign_b_o), 128'(1));
        check("two_exp_b", 128'(bus.exp_b_o), 128'(8'h80));

        // sNaN and canonical qNaN
        directed(32'h7F80_0001, CanonicalNan);
        check("nan_a", 128'(bus.is_nan_a_o), 128'(1));
        check("nan_b", 128'(bus.is_nan_b_o), 128'(1));
        check("signaling", 128'(bus.is_signaling_o), 128'(1));
        check("snan_fclass_a", 128'(bus.fclass_a_o), 128'(10'h100));

        // Smallest +subnormal and -0
        directed(32'h0000_0001, 32'h8000_0000);
        check("sub_a", 128'(bus.is_sub_a_o), 128'(1));
        check("sub_sig_a", 128'(bus.sig_a_o), 128'(24'h00_0001));
        check("sub_fclass_a", 128'(bus.fclass_a_o), 128'(10'h020));
        check("zero_b", 128'(bus.is_zero_b_o), 128'(1));
        @(posedge clk);
        #1;

        // Back-pressure: two accepts fill the buffer, third waits for a drain
        bus.out_ready_i = 1'b0;
        send(32'h4049_0FDB, 32'hFF80_0000);
        send(32'h8000_0400, 32'h7F7F_FFFF);
        bus.op_a_i = 32'hBF80_0000;
        bus.op_b_i = 32'h0040_0000;
        check("full_not_ready", 128'(bus.in_ready_o), 128'(0));
        repeat (2) @(posedge clk);
        #1 check("full_still_blocked", 128'(bus.in_ready_o), 128'(0));
        check("full_valid", 128'(bus.out_valid_o), 128'(1));
        bus.out_ready_i = 1'b1;
        send(32'hBF80_0000, 32'h0040_0000);
        bus.in_valid_i = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1 check("stall_drained", 128'(exp_q.size()), 128'(0));

        // Reset with two results buffered
        bus.out_ready_i = 1'b0;
        send(32'h4120_0000, 32'hC120_0000);
        send(32'h0000_0010, 32'h7FA0_0000);
        bus.in_valid_i = 1'b0;
        #2 reset_i = 1'b0;
        exp_q.delete();
        #1 check("rst_mid_valid", 128'(bus.out_valid_o), 128'(0));
        check("rst_mid_outputs", 128'(observed()), 128'(0));
        @(posedge clk);
        #1 reset_i = 1'b1;
        bus.out_ready_i = 1'b1;
        never_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid_o) never_valid = 1'b0;
        end
        check("no_stale_after_reset", 128'(never_valid), 128'(1));
        @(posedge clk);
        #1;

        // Random stream under random back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 100; i++) send(rand_operand(), rand_operand());
        bus.in_valid_i = 1'b0;
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
        rand_rdy = 1'b0;
        #2 check("stream_drained", 128'(exp_q.size()), 128'(0));
        bus.out_ready_i = 1'b1;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_operand_unpack.md
FPU_OPERAND_UNPACK -- requirements
Module: fpu_operand_unpack

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_i, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid_i, input, 1, operand pair valid.
REQ-004 SHALL have port in_ready_o, output, 1, block can accept a pair.
REQ-005 SHALL have ports op_a_i and op_b_i, input, 32 each, raw IEEE-754 single-precision operands.
REQ-006 SHALL have port out_valid_o, output, 1, unpacked result valid.
REQ-007 SHALL have port out_ready_i, input, 1, consumer accepts the result.
REQ-008 SHALL have ports sign_a_o and sign_b_o, output, 1 each; exp_a_o and exp_b_o, output, 8 each; sig_a_o and sig_b_o, output, 24 each, with the hidden bit in bit 23.
REQ-009 SHALL have ports is_inf_a_o, is_inf_b_o, is_nan_a_o, is_nan_b_o, is_zero_a_o, is_zero_b_o, is_sub_a_o and is_sub_b_o, output, 1 each.
REQ-010 SHALL have port is_signaling_o, output, 1, set when either operand is a signaling NaN.
REQ-011 SHALL have port fclass_a_o, output, 10, RISC-V FCLASS one-hot mask for operand A.

Function
REQ-012 SHALL set hidden bit sig[23] to 1 when exp is nonzero and to 0 when exp is 0; sig[22:0] = mantissa.
REQ-013 SHALL classify each operand as follows: inf = exp FF and mantissa 0; NaN = exp FF and mantissa nonzero; sNaN = NaN and mantissa[22] 0; zero = exp 0 and mantissa 0; subnormal = exp 0 and mantissa nonzero.
REQ-014 SHALL encode fclass_a_o with bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -0, bit4 +0, bit5 +subnormal, bit6 +normal, bit7 +inf, bit8 sNaN, bit9 qNaN; exactly one bit SHALL be set.
REQ-015 SHALL register results with 1-cycle latency: a pair accepted at edge N (in_valid_i and in_ready_o both high) SHALL appear with out_valid_o high after edge N.
REQ-016 SHALL use a 2-entry skid buffer: in_ready_o = NOT (buffer holds 2 entries); in_ready_o SHALL be registered and SHALL NOT depend combinationally on out_ready_i.
REQ-017 SHALL deliver results in acceptance order, with none dropped or duplicated.
REQ-018 SHALL hold all outputs stable while out_valid_o is high and out_ready_i is low.
REQ-019 SHALL, on simultaneous accept and drain with 1 entry held, keep occupancy at 1 and present the next result on the following cycle.
REQ-020 SHALL, when full with out_ready_i high and in_valid_i high, drain one entry and SHALL NOT accept in that cycle.
REQ-021 SHALL keep out_valid_o high while occupancy is at least 1.

Reset
REQ-022 SHALL, while reset_i is low, immediately force occupancy 0, out_valid_o 0, in_ready_o 0, all data outputs 0 and fclass_a_o 0.
REQ-023 SHALL raise in_ready_o on the first clk_i edge after reset_i deasserts.
REQ-024 SHALL, on reset mid-transfer, discard buffered results and not emit them after reset.

Structure
REQ-025 SHALL take canonical NaN 32'h7fc00000, exponent-all-ones 8'hFF, and the FCLASS bit-index constants from the shared FPU package.
REQ-026 SHALL implement per-operand decode in the combinational sub-module fpu_classify, instantiated twice (A and B); the top SHALL hold the handshake and skid buffer only.

Verification
REQ-027 SHALL check: A=3F800000, B=C0000000, out_ready high -> next cycle sign_a 0, exp_a 7F, sig_a 800000, fclass_a bit6; sign_b 1, exp_b 80.
REQ-028 SHALL check: A=7F800001, B=7FC00000 -> is_nan_a 1, is_nan_b 1, is_signaling 1, fclass_a bit8.
REQ-029 SHALL check: A=00000001, B=80000000 -> is_sub_a 1, sig_a 000001, fclass_a bit5, is_zero_b 1.
REQ-030 SHALL check: out_ready low for 4 cycles while in_valid high with 3 distinct pairs -> 2 accepted, in_ready low after 2nd accept, outputs stable; on release results arrive in order, then the 3rd pair is accepted.
REQ-031 SHALL check: stream 100 random pairs with random out_ready -> every result matches the reference model in order, with no loss or duplication.
REQ-032 SHALL check: assert reset_i low with 2 entries buffered -> out_valid_o 0 immediately; after release no stale result appears.
